// File: rtl/cache_lv1_il_pkg.sv
// Shared types and geometry constants for the L1 instruction-cache lookup sequencer.
package cache_lv1_il_pkg;

  localparam int ASSOC_W  = 2;
  localparam int NUM_WAYS = 2 ** ASSOC_W;
  localparam int TAG_W    = 18;
  localparam int IDX_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_FILL,
    S_RESP,
    S_WAIT_DROP
  } state_e;

endpackage

// File: rtl/tag_valid_array_lv1_il.sv
// Tag/valid store for the L1-IL: combinational lookup plus fill and invalidate write ports.
module tag_valid_array_lv1_il
  import cache_lv1_il_pkg::*;
#(
  parameter int ASSOC_WID   = 2,
  parameter int NUM_OF_SETS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_W-1:0]     lk_index,
  input  logic [TAG_W-1:0]     lk_tag,
  output logic                 hit,
  output logic [ASSOC_WID-1:0] hit_way,
  input  logic                 fill_en,
  input  logic [IDX_W-1:0]     fill_index,
  input  logic [ASSOC_WID-1:0] fill_way,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic                 inv_en,
  input  logic [IDX_W-1:0]     inv_index,
  input  logic [TAG_W-1:0]     inv_tag
);

  logic [NUM_WAYS-1:0] valid_q [NUM_OF_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_OF_SETS];
  logic [TAG_W-1:0]    tag_mem [NUM_OF_SETS][NUM_WAYS];

  // Scan from the top way down so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_index][w] && (tag_mem[lk_index][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = ASSOC_WID'(w);
      end
    end
  end

  // Invalidate is applied first so a fill on the same line in the same cycle wins.
  always_comb begin
    valid_d = valid_q;
    if (inv_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (valid_q[inv_index][w] && (tag_mem[inv_index][w] == inv_tag)) begin
          valid_d[inv_index][w] = 1'b0;
        end
      end
    end
    if (fill_en) begin
      valid_d[fill_index][fill_way] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_OF_SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_index][fill_way] <= fill_tag;
    end
  end

endmodule

// File: rtl/icache_lookup_fsm_lv1_il.sv
// L1-IL fetch sequencer: lookup, L2 miss fill and CPU response.
// Optional snoop invalidation port enabled by IL_SNOOP_INVALIDATE_EN.
module icache_lookup_fsm_lv1_il
  import cache_lv1_il_pkg::*;
#(
  parameter int ASSOC_WID   = 2,
  parameter int ADDR_WID    = 32,
  parameter int INDEX_MSB   = 13,
  parameter int INDEX_LSB   = 6,
  parameter int TAG_MSB     = 31,
  parameter int TAG_LSB     = 14,
  parameter int OFFSET_MSB  = 5,
  parameter int OFFSET_LSB  = 0,
  parameter int NUM_OF_SETS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_rd,
  input  logic [ADDR_WID-1:0]  addr_bus_cpu_lv1,
  output logic                 data_in_bus_cpu_lv1,
  output logic                 ctrl_rd,
  output logic [ADDR_WID-1:0]  ctrl_addr,
  input  logic [ASSOC_WID-1:0] lru_replacement_proc,
  output logic [ASSOC_WID-1:0] blk_accessed_main,
  output logic                 lru_update,
  output logic                 lv2_rd,
  output logic [ADDR_WID-1:0]  addr_bus_lv1_lv2,
  input  logic                 data_in_bus_lv1_lv2,
  output logic                 arr_rd_en,
  output logic                 arr_fill_en,
  output logic [ASSOC_WID-1:0] arr_way
`ifdef IL_SNOOP_INVALIDATE_EN
  ,
  input  logic                 inval_req,
  input  logic [ADDR_WID-1:0]  inval_addr,
  output logic                 inval_ack
`endif
);

  localparam int OFF_W = OFFSET_MSB - OFFSET_LSB + 1;

  state_e               state_q, state_d;
  logic [ADDR_WID-1:0]  ctrl_addr_q, ctrl_addr_d;
  logic [ASSOC_WID-1:0] victim_q, victim_d;
  logic [ASSOC_WID-1:0] acc_way_q, acc_way_d;
  logic                 hit;
  logic [ASSOC_WID-1:0] hit_way;
  logic                 fill_en;
  logic                 inv_en;
  logic [IDX_W-1:0]     inv_index;
  logic [TAG_W-1:0]     inv_tag;

`ifdef IL_SNOOP_INVALIDATE_EN
  logic inval_ack_q;
  logic unused_inval_off;

  assign inv_en           = inval_req;
  assign inv_index        = inval_addr[INDEX_MSB:INDEX_LSB];
  assign inv_tag          = inval_addr[TAG_MSB:TAG_LSB];
  assign unused_inval_off = ^inval_addr[OFF_W-1:0];
  assign inval_ack        = inval_ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inval_ack_q <= 1'b0;
    else        inval_ack_q <= inval_req;
  end
`else
  assign inv_en    = 1'b0;
  assign inv_index = '0;
  assign inv_tag   = '0;
`endif

  tag_valid_array_lv1_il #(
    .ASSOC_WID   (ASSOC_WID),
    .NUM_OF_SETS (NUM_OF_SETS)
  ) u_tag_valid (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_index   (ctrl_addr_q[INDEX_MSB:INDEX_LSB]),
    .lk_tag     (ctrl_addr_q[TAG_MSB:TAG_LSB]),
    .hit        (hit),
    .hit_way    (hit_way),
    .fill_en    (fill_en),
    .fill_index (ctrl_addr_q[INDEX_MSB:INDEX_LSB]),
    .fill_way   (victim_q),
    .fill_tag   (ctrl_addr_q[TAG_MSB:TAG_LSB]),
    .inv_en     (inv_en),
    .inv_index  (inv_index),
    .inv_tag    (inv_tag)
  );

  assign ctrl_addr = ctrl_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_addr_q <= '0;
      victim_q    <= '0;
      acc_way_q   <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_addr_q <= ctrl_addr_d;
      victim_q    <= victim_d;
      acc_way_q   <= acc_way_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    ctrl_addr_d         = ctrl_addr_q;
    victim_d            = victim_q;
    acc_way_d           = acc_way_q;
    data_in_bus_cpu_lv1 = 1'b0;
    ctrl_rd             = 1'b0;
    blk_accessed_main   = '0;
    lru_update          = 1'b0;
    lv2_rd              = 1'b0;
    addr_bus_lv1_lv2    = '0;
    arr_rd_en           = 1'b0;
    arr_fill_en         = 1'b0;
    arr_way             = '0;
    fill_en             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_rd) begin
          ctrl_addr_d = addr_bus_cpu_lv1;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        ctrl_rd = 1'b1;
        if (hit) begin
          arr_rd_en         = 1'b1;
          arr_way           = hit_way;
          blk_accessed_main = hit_way;
          acc_way_d         = hit_way;
          state_d           = S_RESP;
        end else begin
          // Victim is frozen here; later LRU changes must not retarget the fill.
          victim_d = lru_replacement_proc;
          state_d  = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        ctrl_rd          = 1'b1;
        lv2_rd           = 1'b1;
        addr_bus_lv1_lv2 = {ctrl_addr_q[ADDR_WID-1:OFF_W], {OFF_W{1'b0}}};
        if (data_in_bus_lv1_lv2) state_d = S_FILL;
      end
      S_FILL: begin
        ctrl_rd           = 1'b1;
        fill_en           = 1'b1;
        arr_fill_en       = 1'b1;
        arr_way           = victim_q;
        blk_accessed_main = victim_q;
        acc_way_d         = victim_q;
        state_d           = S_RESP;
      end
      S_RESP: begin
        ctrl_rd             = 1'b1;
        data_in_bus_cpu_lv1 = 1'b1;
        lru_update          = 1'b1;
        blk_accessed_main   = acc_way_q;
        state_d             = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (!cpu_rd) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
